// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Widths, the hard-wired zero register and WB control bundle layout.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  localparam int REGWRITE_BIT = 1;
  localparam int MEMTOREG_BIT = 0;

  typedef logic [1:0] wb_ctrl_t;

  function automatic wb_ctrl_t pack_wb_ctrl(
    input logic regwrite,
    input logic memtoreg
  );
    wb_ctrl_t c;
    c = '0;
    c[REGWRITE_BIT] = regwrite;
    c[MEMTOREG_BIT] = memtoreg;
    return c;
  endfunction

endpackage

// File: rtl/regfile_core.sv
// Architectural register file: storage, $0 masking and
// two combinational read ports with optional write-first bypass.
module regfile_core
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  generate
    if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_size
      $error("regfile_core: NUM_REGS must equal 2**ADDR_W");
    end
  endgenerate

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr;
  logic              byp_rs;
  logic              byp_rt;

  assign wr = we && (waddr != ADDR_W'(ZERO_REG));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr) begin
      regs[waddr] <= wdata;
    end
  end

  assign byp_rs = (BYPASS != 0) && wr && (rs_addr == waddr);
  assign byp_rt = (BYPASS != 0) && wr && (rt_addr == waddr);

  // $0 check is last so it wins over both bypass and storage
  always_comb begin
    rs_data = regs[rs_addr];
    if (byp_rs) rs_data = wdata;
    if (rs_addr == ADDR_W'(ZERO_REG)) rs_data = '0;
  end

  always_comb begin
    rt_data = regs[rt_addr];
    if (byp_rt) rt_data = wdata;
    if (rt_addr == ADDR_W'(ZERO_REG)) rt_data = '0;
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result mux, effective write enable, commit
// tracking and the register file it writes into.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwrite,
  input  logic              memtoreg,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [ADDR_W-1:0] mem_write_reg,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_en,
  output logic [ADDR_W-1:0] last_wr_reg,
  output logic [DATA_W-1:0] last_wr_data,
  output logic [31:0]       wr_count
);

  wb_ctrl_t         ctrl;
  logic [CNT_W-1:0] cnt;

  assign ctrl = pack_wb_ctrl(regwrite, memtoreg);

  assign wb_data = ctrl[MEMTOREG_BIT] ? read_data : mem_alu_result;
  assign wb_en   = ctrl[REGWRITE_BIT]
                && (mem_write_reg != ADDR_W'(ZERO_REG));

  regfile_core #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS),
    .BYPASS  (BYPASS)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en),
    .waddr  (mem_write_reg),
    .wdata  (wb_data),
    .rs_addr(rs_addr),
    .rt_addr(rt_addr),
    .rs_data(rs_data),
    .rt_data(rt_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_wr_reg  <= '0;
      last_wr_data <= '0;
      cnt          <= '0;
    end else if (wb_en) begin
      last_wr_reg  <= mem_write_reg;
      last_wr_data <= wb_data;
      cnt          <= cnt + 1'b1;
    end
  end

  // narrow counters exist only to make wrap reachable in simulation
  assign wr_count = 32'(cnt);

endmodule
